// File: rtl/nes_pkg.sv
// Shared NES pad definitions: reader state encoding, button bit layout and
// the pad's serial read order. Used by the serial-to-parallel reader and by
// the parallel-to-serial pad emulators.
package nes_pkg;

    // Reader transaction states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LATCH   = 3'd1,
        ST_WAIT0   = 3'd2,
        ST_CLK_LO  = 3'd3,
        ST_CLK_HI  = 3'd4,
        ST_LAST_LO = 3'd5,
        ST_DONE    = 3'd6
    } nes_rd_state_t;

    // Bit positions in the active-high parallel button word
    localparam int unsigned BTN_UP     = 0;
    localparam int unsigned BTN_DOWN   = 1;
    localparam int unsigned BTN_LEFT   = 2;
    localparam int unsigned BTN_RIGHT  = 3;
    localparam int unsigned BTN_START  = 4;
    localparam int unsigned BTN_SELECT = 5;
    localparam int unsigned BTN_A      = 6;
    localparam int unsigned BTN_B      = 7;

    localparam int unsigned NES_BITS = 8;

    // READ_MAP[k] is the button bit carried by the k-th serial bit (A first)
    localparam logic [NES_BITS-1:0][2:0] READ_MAP = {
        3'(BTN_RIGHT), 3'(BTN_LEFT),  3'(BTN_DOWN), 3'(BTN_UP),
        3'(BTN_START), 3'(BTN_SELECT), 3'(BTN_B),   3'(BTN_A)
    };

    // Raw serial samples (index = read order, 0 = pressed) to button word
    function automatic logic [NES_BITS-1:0] nes_remap(input logic [NES_BITS-1:0] raw);
        logic [NES_BITS-1:0] btn;
        btn = '0;
        for (int k = 0; k < int'(NES_BITS); k++) begin
            btn[READ_MAP[k]] = ~raw[k];
        end
        return btn;
    endfunction

    // Button word to serial order (index = read order, 0 = pressed)
    function automatic logic [NES_BITS-1:0] nes_serial_order(input logic [NES_BITS-1:0] btn);
        logic [NES_BITS-1:0] raw;
        raw = '1;
        for (int k = 0; k < int'(NES_BITS); k++) begin
            raw[k] = ~btn[READ_MAP[k]];
        end
        return raw;
    endfunction

    // Largest of three cycle parameters, used to size shared counters
    function automatic int unsigned nes_max3(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer with a configurable asynchronous reset value.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage resynchronization into the clk domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/nes_ser_to_para.sv
// Console-side NES pad reader: drives latch/clock to the pad, shifts in the
// eight serial bits and publishes them as an active-high button word.
module nes_ser_to_para
    import nes_pkg::*;
#(
    parameter int unsigned LATCH_CYC = 144,
    parameter int unsigned HALF_CYC  = 72,
    parameter int unsigned POLL_CYC  = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       poll_en,
    input  logic       poll_now,
    input  logic       NES_Data,
    output logic       NES_Latch,
    output logic       NES_Clock,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(nes_max3(LATCH_CYC, HALF_CYC, POLL_CYC) + 1);

    nes_rd_state_t      state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   timer_q;
    logic [CNT_W-1:0]   timer_d;
    logic [2:0]         bit_q;
    logic [7:0]         shreg_q;
    logic [7:0]         buttons_q;
    logic               latch_q;
    logic               nclk_q;
    logic               valid_q;
    logic               busy_q;

    logic               data_s;
    logic               timer_expired_c;
    logic               start_c;
    logic               latch_done_c;
    logic               half_done_c;

    // Pad data is asynchronous to clk; idle/released level is 1
    sync2 #(
        .RST_VAL (1'b1)
    ) u_data_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (NES_Data),
        .q_o   (data_s)
    );

    // The reload cycle is the first tick of the period, so the timer counts
    // as expired one count early to space timed polls exactly POLL_CYC apart
    assign timer_expired_c = (timer_q <= CNT_W'(1));
    assign start_c         = (state_q == ST_IDLE) && (poll_now || (poll_en && timer_expired_c));
    assign latch_done_c    = (cnt_q == CNT_W'(LATCH_CYC - 1));
    assign half_done_c     = (cnt_q == CNT_W'(HALF_CYC - 1));

    // Poll timer: reload on LATCH entry, otherwise count down and stick at 0
    always_comb begin
        timer_d = timer_q;
        if (start_c) begin
            timer_d = CNT_W'(POLL_CYC);
        end else if (timer_q != '0) begin
            timer_d = timer_q - CNT_W'(1);
        end
    end

    // Poll timer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // Read-transaction FSM with registered pad strobes and result outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shreg_q   <= 8'h00;
            buttons_q <= 8'h00;
            latch_q   <= 1'b0;
            nclk_q    <= 1'b1;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_c) begin
                        state_q <= ST_LATCH;
                        cnt_q   <= '0;
                        latch_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (latch_done_c) begin
                        state_q <= ST_WAIT0;
                        cnt_q   <= '0;
                        latch_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT0: begin
                    // Pad presents A as soon as the latch drops
                    if (half_done_c) begin
                        state_q    <= ST_CLK_LO;
                        cnt_q      <= '0;
                        shreg_q[0] <= data_s;
                        bit_q      <= 3'd1;
                        nclk_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_CLK_LO: begin
                    if (half_done_c) begin
                        state_q <= ST_CLK_HI;
                        cnt_q   <= '0;
                        nclk_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_CLK_HI: begin
                    // Sample late in the high phase, well after the pad shifted
                    if (half_done_c) begin
                        cnt_q          <= '0;
                        shreg_q[bit_q] <= data_s;
                        nclk_q         <= 1'b0;
                        if (bit_q == 3'd7) begin
                            state_q <= ST_LAST_LO;
                        end else begin
                            state_q <= ST_CLK_LO;
                            bit_q   <= 3'(bit_q + 3'd1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_LAST_LO: begin
                    // Eighth pulse returns the pad shift chain to its rest point
                    if (half_done_c) begin
                        state_q   <= ST_DONE;
                        cnt_q     <= '0;
                        nclk_q    <= 1'b1;
                        buttons_q <= nes_remap(shreg_q);
                        valid_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    bit_q   <= 3'd0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    bit_q   <= 3'd0;
                    latch_q <= 1'b0;
                    nclk_q  <= 1'b1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign NES_Latch = latch_q;
    assign NES_Clock = nclk_q;
    assign buttons   = buttons_q;
    assign valid     = valid_q;
    assign busy      = busy_q;

endmodule
